// File: rtl/vdp_regs.sv
// CPU-side register front end of a TMS9918-style VDP: control latch, R0-R7,
// VRAM port A sequencing with auto-increment and read-ahead, status and interrupt.
module vdp_regs #(
   parameter int ADDR_BITS = 14
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 port_sel,
   input  logic                 cpu_wr,
   input  logic                 cpu_rd,
   input  logic [7:0]           cpu_din,
   output logic [7:0]           cpu_dout,
   output logic [ADDR_BITS-1:0] vram_addr,
   output logic [7:0]           vram_din,
   output logic                 vram_wr,
   output logic                 vram_rd,
   input  logic [7:0]           vram_dout,
   input  logic                 vblank,
   input  logic                 sprite_collision,
   input  logic                 too_many_sprites,
   input  logic [4:0]           sprite5,
   output logic [1:0]           mode,
   output logic                 video_on,
   output logic                 vert_retrace_int,
   output logic                 sprite_large,
   output logic                 sprite_enlarged,
   output logic [13:0]          name_table_addr,
   output logic [13:0]          color_table_addr,
   output logic [13:0]          font_addr,
   output logic [13:0]          sprite_attr_addr,
   output logic [13:0]          sprite_pattern_table_addr,
   output logic [3:0]           text_color,
   output logic [3:0]           back_color,
   output logic                 n_int
);

   typedef enum logic [1:0] {IDLE, RD, CAP} seq_t;

   seq_t                 state;
   logic [7:0]           r [0:7];
   logic                 latch;
   logic [7:0]           latch_byte;
   logic [ADDR_BITS-1:0] addr;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [7:0]           read_buf;
   logic                 flag_f;
   logic                 flag_5s;
   logic                 flag_c;

   // Strobes are single-cycle and only accepted in IDLE; the write address is
   // held separately because addr has already advanced during the vram_wr pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         for (int i = 0; i < 8; i++) r[i] <= 8'h00;
         latch      <= 1'b0;
         latch_byte <= 8'h00;
         addr       <= '0;
         wr_addr    <= '0;
         read_buf   <= 8'h00;
         cpu_dout   <= 8'h00;
         vram_din   <= 8'h00;
         vram_wr    <= 1'b0;
         vram_rd    <= 1'b0;
         flag_f     <= 1'b0;
         flag_5s    <= 1'b0;
         flag_c     <= 1'b0;
      end else begin
         vram_wr <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_wr) begin
                  if (port_sel) begin
                     if (!latch) begin
                        latch_byte <= cpu_din;
                        latch      <= 1'b1;
                     end else begin
                        latch <= 1'b0;
                        if (cpu_din[7]) begin
                           r[cpu_din[2:0]] <= latch_byte;
                        end else begin
                           addr <= ADDR_BITS'({cpu_din[5:0], latch_byte});
                           if (!cpu_din[6]) begin
                              vram_rd <= 1'b1;
                              state   <= RD;
                           end
                        end
                     end
                  end else begin
                     vram_wr  <= 1'b1;
                     vram_din <= cpu_din;
                     wr_addr  <= addr;
                     read_buf <= cpu_din;
                     addr     <= addr + ADDR_BITS'(1);
                     latch    <= 1'b0;
                  end
               end else if (cpu_rd) begin
                  latch <= 1'b0;
                  if (port_sel) begin
                     cpu_dout <= {flag_f, flag_5s, flag_c, sprite5};
                     flag_f   <= 1'b0;
                     flag_5s  <= 1'b0;
                     flag_c   <= 1'b0;
                  end else begin
                     cpu_dout <= read_buf;
                     vram_rd  <= 1'b1;
                     state    <= RD;
                  end
               end
            end
            RD: begin
               vram_rd <= 1'b0;
               state   <= CAP;
            end
            CAP: begin
               read_buf <= vram_dout;
               addr     <= addr + ADDR_BITS'(1);
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // Flag sources override a same-cycle status-read clear.
         if (vblank)           flag_f  <= 1'b1;
         if (too_many_sprites) flag_5s <= 1'b1;
         if (sprite_collision) flag_c  <= 1'b1;
      end
   end

   assign vram_addr = vram_wr ? wr_addr : addr;

   always_comb begin
      mode = 2'd1;
      if (r[1][4])      mode = 2'd0;
      else if (r[0][1]) mode = 2'd2;
      else if (r[1][3]) mode = 2'd3;
   end

   assign video_on                  = r[1][6];
   assign vert_retrace_int          = r[1][5];
   assign sprite_large              = r[1][1];
   assign sprite_enlarged           = r[1][0];
   assign name_table_addr           = {r[2][3:0], 10'b0};
   assign color_table_addr          = {r[3], 6'b0};
   assign font_addr                 = {r[4][2:0], 11'b0};
   assign sprite_attr_addr          = {r[5][6:0], 7'b0};
   assign sprite_pattern_table_addr = {r[6][2:0], 11'b0};
   assign text_color                = r[7][7:4];
   assign back_color                = r[7][3:0];
   assign n_int                     = !(flag_f && r[1][5]);

endmodule

// File: tb/tb_vdp_regs.sv
// Bench for vdp_regs: directed test-plan steps followed by random CPU traffic,
// checked against a transaction-level model of the register file and VRAM.
module tb_vdp_regs;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        port_sel = 1'b0;
   logic        cpu_wr = 1'b0;
   logic        cpu_rd = 1'b0;
   logic [7:0]  cpu_din = 8'h00;
   logic [7:0]  cpu_dout;
   logic [13:0] vram_addr;
   logic [7:0]  vram_din;
   logic        vram_wr;
   logic        vram_rd;
   logic [7:0]  vram_dout = 8'h00;
   logic        vblank = 1'b0;
   logic        sprite_collision = 1'b0;
   logic        too_many_sprites = 1'b0;
   logic [4:0]  sprite5 = 5'd0;
   logic [1:0]  mode;
   logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
   logic [13:0] name_table_addr, color_table_addr, font_addr;
   logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
   logic [3:0]  text_color, back_color;
   logic        n_int;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vdp_regs dut (
      .clk(clk), .reset(reset), .port_sel(port_sel), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vram_addr(vram_addr), .vram_din(vram_din),
      .vram_wr(vram_wr), .vram_rd(vram_rd), .vram_dout(vram_dout), .vblank(vblank),
      .sprite_collision(sprite_collision), .too_many_sprites(too_many_sprites),
      .sprite5(sprite5), .mode(mode), .video_on(video_on),
      .vert_retrace_int(vert_retrace_int), .sprite_large(sprite_large),
      .sprite_enlarged(sprite_enlarged), .name_table_addr(name_table_addr),
      .color_table_addr(color_table_addr), .font_addr(font_addr),
      .sprite_attr_addr(sprite_attr_addr),
      .sprite_pattern_table_addr(sprite_pattern_table_addr),
      .text_color(text_color), .back_color(back_color), .n_int(n_int)
   );

   // VRAM environment: one-cycle read latency
   logic [7:0] vram [0:16383];
   always @(posedge clk) begin
      if (vram_wr) vram[vram_addr] <= vram_din;
      if (vram_rd) vram_dout <= vram[vram_addr];
   end

   // reference model
   logic [7:0] ref_mem [0:16383];
   logic [7:0] m_reg [0:7];
   bit         m_latch;
   logic [7:0] m_lb;
   int         m_addr;
   logic [7:0] m_rbuf;
   logic [7:0] m_dout;
   bit         m_f, m_5s, m_c;
   logic [21:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check("wr_rd_exclusive", {31'd0, vram_wr & vram_rd}, 32'd0);
         if (vram_wr) begin
            check("wr_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) check("vram_write", {vram_addr, vram_din}, exp_q.pop_front());
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
      m_latch = 0; m_lb = 8'h00; m_addr = 0; m_rbuf = 8'h00; m_dout = 8'h00;
      m_f = 0; m_5s = 0; m_c = 0;
   endtask

   function automatic int exp_mode();
      if (m_reg[1][4]) return 0;
      if (m_reg[0][1]) return 2;
      if (m_reg[1][3]) return 3;
      return 1;
   endfunction

   task automatic check_outputs();
      check("mode", mode, exp_mode());
      check("video_on", video_on, m_reg[1][6]);
      check("vert_retrace_int", vert_retrace_int, m_reg[1][5]);
      check("sprite_large", sprite_large, m_reg[1][1]);
      check("sprite_enlarged", sprite_enlarged, m_reg[1][0]);
      check("name_table_addr", name_table_addr, (m_reg[2] % 16) * 1024);
      check("color_table_addr", color_table_addr, m_reg[3] * 64);
      check("font_addr", font_addr, (m_reg[4] % 8) * 2048);
      check("sprite_attr_addr", sprite_attr_addr, (m_reg[5] % 128) * 128);
      check("sprite_pattern_addr", sprite_pattern_table_addr, (m_reg[6] % 8) * 2048);
      check("text_color", text_color, m_reg[7] / 16);
      check("back_color", back_color, m_reg[7] % 16);
      check("n_int", n_int, (m_f && m_reg[1][5]) ? 0 : 1);
      check("vram_addr_idle", vram_addr, m_addr);
      check("cpu_dout_hold", cpu_dout, m_dout);
      check("vram_wr_idle", vram_wr, 0);
      check("vram_rd_idle", vram_rd, 0);
   endtask

   // one-cycle strobe; returns at the falling edge one cycle after the strobe edge
   task automatic pulse(input bit ps, input bit wr, input bit rd, input logic [7:0] d, input bit vb);
      @(negedge clk);
      port_sel = ps; cpu_wr = wr; cpu_rd = rd; cpu_din = d; vblank = vb;
      @(negedge clk);
      cpu_wr = 0; cpu_rd = 0; vblank = 0;
   endtask

   // called one cycle after the strobe edge of any access that prefetches
   task automatic prefetch_check();
      check("prefetch_rd", vram_rd, 1);
      check("prefetch_addr", vram_addr, m_addr);
      m_rbuf = ref_mem[m_addr];
      m_addr = (m_addr + 1) % 16384;
      repeat (2) @(negedge clk);
   endtask

   task automatic ctrl_write(input logic [7:0] d);
      bit pf = 0;
      if (!m_latch) begin
         m_lb = d; m_latch = 1;
      end else begin
         m_latch = 0;
         if (d[7]) m_reg[d % 8] = m_lb;
         else begin
            m_addr = (d % 64) * 256 + m_lb;
            pf = !d[6];
         end
      end
      pulse(1, 1, 0, d, 0);
      if (pf) prefetch_check();
      else repeat (2) @(negedge clk);
      check_outputs();
   endtask

   task automatic data_write(input logic [7:0] d, input bit with_rd);
      exp_q.push_back({m_addr[13:0], d});
      ref_mem[m_addr] = d;
      m_rbuf = d; m_latch = 0;
      pulse(0, 1, with_rd, d, 0);
      check("wr_pulse", vram_wr, 1);
      m_addr = (m_addr + 1) % 16384;
      @(negedge clk);
      check("wr_one_cycle", vram_wr, 0);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic data_read();
      m_dout = m_rbuf; m_latch = 0;
      pulse(0, 0, 1, 8'h00, 0);
      check("data_read", cpu_dout, m_dout);
      prefetch_check();
      check_outputs();
   endtask

   task automatic status_read(input bit vb);
      sprite5 = 5'($urandom_range(0, 31));
      m_dout = {m_f, m_5s, m_c, sprite5};
      m_f = vb; m_5s = 0; m_c = 0; m_latch = 0;
      pulse(1, 0, 1, 8'h00, vb);
      check("status_read", cpu_dout, m_dout);
      repeat (2) @(negedge clk);
      check_outputs();
   endtask

   task automatic src_pulse(input bit vb, input bit tm, input bit col);
      @(negedge clk);
      vblank = vb; too_many_sprites = tm; sprite_collision = col;
      @(negedge clk);
      vblank = 0; too_many_sprites = 0; sprite_collision = 0;
      if (vb) m_f = 1;
      if (tm) m_5s = 1;
      if (col) m_c = 1;
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
      model_reset();
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) begin
         vram[i] = 8'($urandom);
         ref_mem[i] = vram[i];
      end
      vram[16383] = 8'h12; ref_mem[16383] = 8'h12;
      vram[0] = 8'h34;     ref_mem[0] = 8'h34;
      repeat (3) @(negedge clk);
      reset = 0;
      model_reset();

      check("reset_mode", mode, 1);
      check("reset_n_int", n_int, 1);
      check("reset_name_table", name_table_addr, 0);
      check("reset_vram_addr", vram_addr, 0);
      check("reset_video_on", video_on, 0);
      check_outputs();

      // register writes
      ctrl_write(8'hF5); ctrl_write(8'h87);
      check("text_color_F", text_color, 4'hF);
      check("back_color_5", back_color, 4'h5);
      ctrl_write(8'h10); ctrl_write(8'h81);
      check("mode_text", mode, 0);
      ctrl_write(8'h00); ctrl_write(8'h81);
      ctrl_write(8'h02); ctrl_write(8'h80);
      check("mode_2", mode, 2);
      ctrl_write(8'h00); ctrl_write(8'h80);
      ctrl_write(8'h08); ctrl_write(8'hF9);   // index bits 6:3 ignored -> R1
      check("mode_3", mode, 3);

      // read setup at 0x3FFF wraps through 0x0000
      ctrl_write(8'hFF); ctrl_write(8'h3F);
      data_read();
      check("wrap_read_1", cpu_dout, 8'h12);
      check("addr_after_read_1", vram_addr, 14'h0001);
      data_read();
      check("wrap_read_2", cpu_dout, 8'h34);

      // write setup
      ctrl_write(8'h00); ctrl_write(8'h40);
      data_write(8'hAA, 0);
      data_write(8'hBB, 0);
      check("vram_0", vram[0], 8'hAA);
      check("vram_1", vram[1], 8'hBB);

      // interrupt
      ctrl_write(8'h20); ctrl_write(8'h81);
      src_pulse(1, 0, 0);
      check("n_int_low", n_int, 0);
      status_read(0);
      check("status_f", cpu_dout[7], 1);
      check("n_int_high", n_int, 1);
      status_read(0);
      check("status_f_cleared", cpu_dout[7], 0);
      // vblank coincident with status read: old F returned, F set afterwards
      status_read(1);
      check("vblank_wins_old", cpu_dout[7], 0);
      check("vblank_wins_int", n_int, 0);
      status_read(0);
      check("vblank_wins_new", cpu_dout[7], 1);

      // latch cleared by status read
      ctrl_write(8'h55);
      status_read(0);
      ctrl_write(8'h00); ctrl_write(8'h40);
      check("latch_reset_addr", vram_addr, 14'h0000);

      // cpu_wr with cpu_rd: the write wins
      data_write(8'h5A, 1);

      // strobe during a prefetch is dropped
      m_dout = m_rbuf; m_latch = 0;
      pulse(0, 0, 1, 8'h00, 0);
      port_sel = 0; cpu_wr = 1; cpu_din = 8'h99;
      @(negedge clk);
      cpu_wr = 0;
      check("dropped_no_wr", vram_wr, 0);
      m_rbuf = ref_mem[m_addr];
      m_addr = (m_addr + 1) % 16384;
      @(negedge clk);
      check_outputs();

      // reset in the middle of a prefetch
      pulse(0, 0, 1, 8'h00, 0);
      reset = 1;
      @(negedge clk);
      reset = 0;
      model_reset();
      @(negedge clk);
      check_outputs();
      data_read();
      check("read_buf_after_reset", cpu_dout, 8'h00);

      // random traffic
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 8))
            0: begin
               ctrl_write(8'($urandom));
               ctrl_write({1'b1, 4'($urandom), 3'($urandom_range(0, 7))});
            end
            1: begin
               ctrl_write(8'($urandom));
               ctrl_write({2'b01, 6'($urandom)});
            end
            2: begin
               ctrl_write(8'($urandom));
               ctrl_write({2'b00, 6'($urandom)});
            end
            3: data_write(8'($urandom), 0);
            4: data_read();
            5: status_read(1'($urandom));
            6: src_pulse(1'($urandom), 1'($urandom), 1'($urandom));
            7: ctrl_write(8'($urandom));
            default: data_write(8'($urandom), 1);
         endcase
      end
      check("write_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
